// File: rtl/rand_dly_stim_if.sv
// Handshake/status bundle between a stimulus controller and rand_dly_stim_gen.
// The seed signal exists only when STIM_SEED_PORT_EN is defined.
interface rand_dly_stim_if #(
  parameter int LFSR_W = 16,
  parameter int CNT_W  = 8
);
  logic             start;
  logic             d;
  logic             d_upd;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] iter_cnt;
`ifdef STIM_SEED_PORT_EN
  logic [LFSR_W-1:0] seed;

  modport master (output start, output seed,
                  input d, input d_upd, input busy, input done, input iter_cnt);
  modport slave  (input start, input seed,
                  output d, output d_upd, output busy, output done, output iter_cnt);
`else
  modport master (output start,
                  input d, input d_upd, input busy, input done, input iter_cnt);
  modport slave  (input start,
                  output d, output d_upd, output busy, output done, output iter_cnt);
`endif
endinterface

// File: rtl/rand_dly_stim_gen.sv
// LFSR-driven stimulus source: NUM_ITER updates of d, each after a random 0..2^DLY_W-1 cycle gap.
// Optional macro STIM_SEED_PORT_EN adds a per-run seed input sampled on the IDLE->LOAD edge.
module rand_dly_stim_gen #(
  parameter int                LFSR_W   = 16,
  parameter logic [LFSR_W-1:0] SEED     = 16'hACE1,
  parameter int                DLY_W    = 2,
  parameter int                NUM_ITER = 20,
  parameter int                CNT_W    = 8
) (
  input logic              clk,
  input logic              rst,
  rand_dly_stim_if.slave   stim
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DRIVE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Galois toggle mask for x^16+x^14+x^13+x^11+1, right-shifting form.
  localparam logic [LFSR_W-1:0] TAPS      = LFSR_W'(16'hB400);
  localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(NUM_ITER - 1);

  logic [2:0]        r_state;
  logic [LFSR_W-1:0] r_lfsr;
  logic [DLY_W-1:0]  r_dly_cnt;
  logic              r_d;
  logic              r_d_upd;
  logic              r_done;
  logic [CNT_W-1:0]  r_iter_cnt;

  logic [LFSR_W-1:0] w_lfsr_next;
  logic [LFSR_W-1:0] w_run_seed;

  assign w_lfsr_next = {1'b0, r_lfsr[LFSR_W-1:1]} ^ (r_lfsr[0] ? TAPS : '0);

`ifdef STIM_SEED_PORT_EN
  // A zero seed would lock the LFSR, so fall back to the reset seed.
  assign w_run_seed = (stim.seed != '0) ? stim.seed : SEED;
`else
  assign w_run_seed = r_lfsr;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_lfsr     <= SEED;
      r_dly_cnt  <= '0;
      r_d        <= 1'b0;
      r_d_upd    <= 1'b0;
      r_done     <= 1'b0;
      r_iter_cnt <= '0;
    end else begin
      // NOTE: pulse outputs default low every edge; only the owning state raises them.
      r_d_upd <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (stim.start) begin
            r_iter_cnt <= '0;
            r_lfsr     <= w_run_seed;
            r_state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          // NOTE: non-blocking, so the delay and branch use the pre-advance LFSR value.
          r_dly_cnt <= r_lfsr[DLY_W-1:0];
          r_lfsr    <= w_lfsr_next;
          r_state   <= (r_lfsr[DLY_W-1:0] == '0) ? S_DRIVE : S_WAIT;
        end
        S_WAIT: begin
          r_dly_cnt <= r_dly_cnt - 1'b1;
          if (r_dly_cnt == DLY_W'(1)) begin
            r_state <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          r_d        <= r_lfsr[LFSR_W-1];
          r_lfsr     <= w_lfsr_next;
          r_d_upd    <= 1'b1;
          r_iter_cnt <= r_iter_cnt + 1'b1;
          r_state    <= (r_iter_cnt == LAST_ITER) ? S_DONE : S_LOAD;
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stim.d        = r_d;
  assign stim.d_upd    = r_d_upd;
  assign stim.busy     = (r_state != S_IDLE);
  assign stim.done     = r_done;
  assign stim.iter_cnt = r_iter_cnt;

endmodule

// File: tb/tb_rand_dly_stim_gen.sv
// Bench for rand_dly_stim_gen: three instances (seeds ACE1, 0004, 0003) checked cycle by cycle
// against a transaction-level LFSR model that predicts every d value and update time.
module tb_rand_dly_stim_gen;

  localparam int NUM = 20;
  localparam int NDUT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start_v [NDUT];
  logic       d_v     [NDUT];
  logic       upd_v   [NDUT];
  logic       busy_v  [NDUT];
  logic       done_v  [NDUT];
  logic [7:0] cnt_v   [NDUT];

  int checks = 0;
  int failures = 0;

  logic [15:0] lfsr_m [NDUT];
  logic        d_m    [NDUT];

  function automatic logic [15:0] seed_of(input int k);
    return (k == 0) ? 16'hACE1 : (k == 1) ? 16'h0004 : 16'h0003;
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam logic [15:0] P_SEED = (g == 0) ? 16'hACE1 : (g == 1) ? 16'h0004 : 16'h0003;
    rand_dly_stim_if #(.LFSR_W(16), .CNT_W(8)) u_if ();
    assign u_if.start = start_v[g];
`ifdef STIM_SEED_PORT_EN
    assign u_if.seed = 16'h0000;
`endif
    assign d_v[g]    = u_if.d;
    assign upd_v[g]  = u_if.d_upd;
    assign busy_v[g] = u_if.busy;
    assign done_v[g] = u_if.done;
    assign cnt_v[g]  = u_if.iter_cnt;
    rand_dly_stim_gen #(.LFSR_W(16), .SEED(P_SEED), .DLY_W(2), .NUM_ITER(NUM), .CNT_W(8))
      u_dut (.clk(clk), .rst(rst), .stim(u_if));
  end

  // Polynomial x^16+x^14+x^13+x^11+1: when the bit shifted out is 1, taps 16,14,13,11 flip.
  function automatic logic [15:0] poly_step(input logic [15:0] x);
    logic [15:0] y;
    y = x >> 1;
    if (x[0]) begin
      y[15] = ~y[15]; y[13] = ~y[13]; y[12] = ~y[12]; y[10] = ~y[10];
    end
    return y;
  endfunction

  function automatic void reset_model();
    for (int k = 0; k < NDUT; k++) begin
      lfsr_m[k] = seed_of(k);
      d_m[k]    = 1'b0;
    end
  endfunction

  task automatic fail_msg(input string tag, input string what, input int n, input int got, input int exp);
    failures++;
    $display("FAIL %s %s at cycle %0d: got %0d expected %0d", tag, what, n, got, exp);
  endtask

  task automatic cmp(input string tag, input string what, input int n, input int got, input int exp);
    checks++;
    if (got !== exp) fail_msg(tag, what, n, got, exp);
  endtask

  // Starts a run on instance k at a negedge and checks every following negedge against the model.
  task automatic run_check(input int k, input string tag, input bit hold, input bit poke,
                           input int abort_at, input int tail,
                           output int first_lat, output logic first_d);
    int dly [NUM];
    logic dv [NUM];
    int t_upd [NUM];
    int t_done, t_abort, p_drive, p_wait, last_n, nup, ndone, exp_cnt, j;
    logic [15:0] s;
    logic exp_d, exp_upd, exp_busy, exp_done;
`ifdef STIM_SEED_PORT_EN
    lfsr_m[k] = seed_of(k);
`endif
    s = lfsr_m[k];
    for (int i = 0; i < NUM; i++) begin
      dly[i] = int'(s[1:0]);
      s = poly_step(s);
      dv[i] = s[15];
      s = poly_step(s);
    end
    lfsr_m[k] = s;
    t_upd[0] = 3 + dly[0];
    for (int i = 1; i < NUM; i++) t_upd[i] = t_upd[i-1] + 2 + dly[i];
    t_done = t_upd[NUM-1] + 1;
    p_drive = t_upd[3] - 1;
    p_wait = -1;
    for (int i = 1; i < NUM; i++) if (dly[i] > 0 && p_wait < 0) p_wait = t_upd[i] - 2;
    t_abort = -1;
    if (abort_at > 0) begin
      for (int i = abort_at - 1; i < NUM; i++) if (dly[i] > 0 && t_abort < 0) t_abort = t_upd[i] - 2;
      if (t_abort < 0) t_abort = t_upd[abort_at-1] - 1;
    end
    last_n = (t_abort > 0) ? t_abort + tail : t_done + tail;
    exp_d = d_m[k];
    nup = 0; ndone = 0; first_lat = -1; first_d = 1'b0;
    start_v[k] = 1'b1;
    for (int n = 1; n <= last_n; n++) begin
      @(negedge clk);
      if (t_abort > 0 && n > t_abort) begin
        exp_upd = 0; exp_busy = 0; exp_done = 0; exp_cnt = 0; exp_d = 0;
      end else begin
        exp_upd = 0; exp_cnt = 0; j = -1;
        for (int i = 0; i < NUM; i++) begin
          if (t_upd[i] == n) begin exp_upd = 1; j = i; end
          if (t_upd[i] <= n) exp_cnt++;
        end
        if (exp_upd) exp_d = dv[j];
        exp_busy = (n <= t_upd[NUM-1]);
        exp_done = (n == t_done);
      end
      cmp(tag, "d_upd", n, int'(upd_v[k]), int'(exp_upd));
      cmp(tag, "done", n, int'(done_v[k]), int'(exp_done));
      cmp(tag, "busy", n, int'(busy_v[k]), int'(exp_busy));
      cmp(tag, "d", n, int'(d_v[k]), int'(exp_d));
      cmp(tag, "iter_cnt", n, int'(cnt_v[k]), exp_cnt);
      if (upd_v[k] === 1'b1) begin
        nup++;
        if (first_lat < 0) begin first_lat = n; first_d = d_v[k]; end
      end
      if (done_v[k] === 1'b1) ndone++;
      if (t_abort > 0 && n == t_abort + 1) rst = 1'b0;
      start_v[k] = hold | (poke && (n == p_drive || n == p_wait));
      if (n == t_abort) begin
        cmp(tag, "busy before rst", n, int'(busy_v[k]), 1);
        #2 rst = 1'b1;
        #1;
        cmp(tag, "async busy", n, int'(busy_v[k]), 0);
        cmp(tag, "async iter_cnt", n, int'(cnt_v[k]), 0);
        cmp(tag, "async d", n, int'(d_v[k]), 0);
        cmp(tag, "async d_upd", n, int'(upd_v[k]), 0);
        cmp(tag, "async done", n, int'(done_v[k]), 0);
      end
    end
    if (t_abort > 0) begin
      cmp(tag, "done pulses after abort", last_n, ndone, 0);
      reset_model();
    end else begin
      cmp(tag, "d_upd pulses", last_n, nup, NUM);
      cmp(tag, "done pulses", last_n, ndone, 1);
      d_m[k] = exp_d;
    end
  endtask

  int lat0, lat;
  logic fd0, fd;

  task automatic test_reset();
    for (int k = 0; k < NDUT; k++) start_v[k] = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    reset_model();
    for (int k = 0; k < NDUT; k++) begin
      cmp("reset", "busy", 0, int'(busy_v[k]), 0);
      cmp("reset", "d", 0, int'(d_v[k]), 0);
      cmp("reset", "d_upd", 0, int'(upd_v[k]), 0);
      cmp("reset", "done", 0, int'(done_v[k]), 0);
      cmp("reset", "iter_cnt", 0, int'(cnt_v[k]), 0);
    end
    run_check(0, "reset_mid", 1'b0, 1'b0, 2, 4, lat, fd);
  endtask

  task automatic test_default_run();
    run_check(0, "default", 1'b0, 1'b0, 0, 4, lat0, fd0);
    cmp("default", "final iter_cnt", 0, int'(cnt_v[0]), NUM);
  endtask

  task automatic test_zero_delay();
    run_check(1, "zero_dly", 1'b0, 1'b0, 0, 3, lat, fd);
    cmp("zero_dly", "first d_upd latency", 0, lat, 3);
  endtask

  task automatic test_max_delay();
    run_check(2, "max_dly", 1'b0, 1'b0, 0, 3, lat, fd);
    cmp("max_dly", "first d_upd latency", 0, lat, 6);
  endtask

  task automatic test_start_while_busy();
    for (int k = 0; k < NDUT; k++) run_check(k, "busy_start", 1'b0, 1'b1, 0, 3, lat, fd);
  endtask

  task automatic test_back_to_back();
    run_check(0, "b2b_first", 1'b1, 1'b0, 0, 0, lat, fd);
    cmp("b2b_first", "busy at done", 0, int'(busy_v[0]), 0);
    run_check(0, "b2b_second", 1'b0, 1'b0, 0, 3, lat, fd);
  endtask

  task automatic test_abort();
    run_check(0, "abort", 1'b0, 1'b0, 7, 6, lat, fd);
    run_check(0, "replay", 1'b0, 1'b0, 0, 3, lat, fd);
    cmp("replay", "first latency vs default run", 0, lat, lat0);
    cmp("replay", "first d vs default run", 0, int'(fd), int'(fd0));
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_zero_delay();
    test_max_delay();
    test_start_while_busy();
    test_back_to_back();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rand_dly_stim_gen.md
Name: rand_dly_stim_gen

Overview:
Synthesizable stimulus source that drives the d input of the edge-sensitive D flop cell. It runs a fixed number of iterations. Each iteration waits a pseudo-random number of clk rising edges, then drives a new pseudo-random d bit, so the downstream flop sees data changes between clock edges. It is used in gate/switch-level benches and in FPGA bring-up where $random is not available.

Parameters:
LFSR_W, 16, LFSR width; feedback polynomial fixed to x^16+x^14+x^13+x^11+1 (Galois form).
SEED, 16'hACE1, LFSR reset value; must be nonzero.
DLY_W, 2, delay field width; each delay is 0..2^DLY_W-1 clk edges.
NUM_ITER, 20, d updates per run; range 1..2^CNT_W-1.
CNT_W, 8, width of iter_cnt.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  level; sampled only in IDLE
d  output  1  stimulus bit to flop d input; registered
d_upd  output  1  one-cycle pulse in the cycle after d is loaded
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the run completes
iter_cnt  output  CNT_W  number of d updates completed in the current run

Behaviour:
- Reset (asynchronous, immediate, any state):
  - state=IDLE, lfsr=SEED, d=0, d_upd=0, busy=0, done=0, iter_cnt=0, dly_cnt=0.
- The LFSR advances only on the LOAD and DRIVE edges. It holds in all other states.
- IDLE:
  - start=1 -> LOAD; iter_cnt<=0 on that edge.
  - lfsr is not reloaded, so consecutive runs continue the sequence.
- LOAD (1 cycle):
  - dly_cnt<=lfsr[DLY_W-1:0]; lfsr advances.
  - Next state is DRIVE if lfsr[DLY_W-1:0]==0, otherwise WAIT.
- WAIT:
  - dly_cnt decrements on each edge.
  - When dly_cnt==1, next state is DRIVE. WAIT therefore occupies exactly dly cycles.
- DRIVE (1 cycle):
  - d<=lfsr[LFSR_W-1]; lfsr advances; d_upd<=1 for the next cycle; iter_cnt<=iter_cnt+1.
  - If iter_cnt==NUM_ITER-1, next state is DONE; otherwise LOAD.
- DONE (1 cycle):
  - done<=1 for the next cycle; next state is IDLE.
  - d and iter_cnt hold until the next start.
- Timing:
  - Iteration period = 2+dly cycles.
  - First d_upd is high 3+dly cycles after the edge that samples start.
- d changes only on DRIVE edges. d_upd is high even when the new d equals the old d.
- Boundary conditions:
  - start while busy is ignored; it has no effect on the run or on iter_cnt.
  - start held high across DONE begins a new run on the first IDLE edge.
  - NUM_ITER=1: LOAD -> (WAIT) -> DRIVE -> DONE.
  - dly_cnt never underflows: WAIT is entered only with dly_cnt>=1.
  - rst during any state aborts the run with no done pulse. A subsequent start replays the sequence from SEED.

Optional Feature:
Macro STIM_SEED_PORT_EN.
- Defined:
  - Adds port seed, input, LFSR_W bits.
  - On the IDLE->LOAD edge, lfsr<=seed if seed!=0, otherwise lfsr<=SEED (this avoids LFSR lockup).
  - Each run is therefore reproducible from its seed.
- Undefined:
  - Port is absent; lfsr is loaded only at reset, and the behaviour is as above.

Test Plan:
1. Reset: pulse rst mid-cycle, asynchronously -> d=0, busy=0, done=0, d_upd=0, iter_cnt=0 immediately, before the next clk edge.
2. Default run: start=1 for one cycle.
   - Expect exactly 20 d_upd pulses and iter_cnt ending at 20.
   - done pulses once, one cycle after the DRIVE edge that completes the 20th iteration.
   - Every d value and gap must match a bit-exact Galois LFSR model from 16'hACE1.
3. Zero delay: SEED=16'h0004 (lfsr[1:0]=0).
   - First d_upd is high 3 cycles after the start-sample edge.
   - Model gaps of 0 give a 2-cycle iteration period.
4. Max delay: SEED=16'h0003 (dly=3) -> first d_upd is high 6 cycles after the start-sample edge; busy is high throughout.
5. Start while busy: pulse start during WAIT and during DRIVE -> no restart, iter_cnt continues 1..20, a single done.
6. Abort: assert rst while in WAIT of iteration 7 -> no done pulse. A new start reproduces iteration 1 of test 2 exactly. With STIM_SEED_PORT_EN defined, seed=0 gives the same sequence as SEED.
